// File: rtl/codificador_sequencial.sv
// rtl/codificador_sequencial.sv - sequential priority encoder: captures an 8-bit snapshot and emits each set index with a valid/ready handshake.
// Optional build macro CODIFICADOR_MSB_FIRST_EN: emit indices highest-first instead of lowest-first.
module codificador_sequencial (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] d,
  input  logic       start,
  input  logic       ready,
  output logic [2:0] a,
  output logic       valid,
  output logic       busy,
  output logic       done,
  output logic [3:0] total
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t     state;
  logic [7:0] mask;
  logic [7:0] mask_next;

  // Index of the next bit to emit; the loop direction sets the emission order.
  function automatic logic [2:0] pick(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
`ifdef CODIFICADOR_MSB_FIRST_EN
    for (int i = 0; i < 8; i++)
      if (m[i]) idx = 3'(i);
`else
    for (int i = 7; i >= 0; i--)
      if (m[i]) idx = 3'(i);
`endif
    return idx;
  endfunction

  function automatic logic [3:0] popcount(input logic [7:0] m);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++)
      cnt = cnt + {3'd0, m[i]};
    return cnt;
  endfunction

  always_comb begin
    mask_next = mask & ~(8'd1 << a);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mask  <= 8'd0;
      a     <= 3'd0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      total <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mask  <= d;
            total <= popcount(d);
            a     <= pick(d);
            busy  <= 1'b1;
            if (d != 8'd0) begin
              state <= SCAN;
              valid <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (ready) begin
            mask <= mask_next;
            if (mask_next == 8'd0) begin
              state <= DONE;
              valid <= 1'b0;
              a     <= 3'd0;
              done  <= 1'b1;
            end else begin
              a <= pick(mask_next);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          valid <= 1'b0;
          a     <= 3'd0;
          mask  <= 8'd0;
        end
        default: begin
          state <= IDLE;
          mask  <= 8'd0;
          a     <= 3'd0;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_codificador_sequencial.sv
// tb/tb_codificador_sequencial.sv - self-checking bench for codificador_sequencial against an index-list reference model.
module tb_codificador_sequencial;

  logic       clk;
  logic       rst_n;
  logic [7:0] d;
  logic       start;
  logic       ready;
  logic [2:0] a;
  logic       valid;
  logic       busy;
  logic       done;
  logic [3:0] total;

  int checks = 0;
  int errors = 0;

  codificador_sequencial dut (
    .clk(clk), .rst_n(rst_n), .d(d), .start(start), .ready(ready),
    .a(a), .valid(valid), .busy(busy), .done(done), .total(total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected emission order: the set bit positions of the snapshot, sorted.
  function automatic void model(input logic [7:0] snap, output int q[$], output int cnt);
    q = {};
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (snap[i]) begin
`ifdef CODIFICADOR_MSB_FIRST_EN
        q.push_front(i);
`else
        q.push_back(i);
`endif
        cnt++;
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; d = 8'hFF; ready = 1'b1;
    step(); step();
    checks++; if ({a, valid, busy, done, total} !== 10'd0) begin errors++; $display("FAIL reset_outputs got a=%0d v=%0b b=%0b dn=%0b t=%0d want all 0", a, valid, busy, done, total); end
    start = 1'b0; rst_n = 1'b1;
    step();
    checks++; if ({a, valid, busy, done, total} !== 10'd0) begin errors++; $display("FAIL idle_after_reset got a=%0d v=%0b b=%0b dn=%0b t=%0d want all 0", a, valid, busy, done, total); end
  endtask

  // mode 0: ready always 1, mode 1: ready toggles 1,0,1,0..., mode 2: random ready
  task automatic test_capture(input logic [7:0] snap, input int mode);
    int exp[$];
    int cnt;
    int idx;
    int cyc;
    logic r;
    model(snap, exp, cnt);
    d = snap; start = 1'b1; ready = 1'b0;
    step();
    start = 1'b0; d = 8'($urandom);
    idx = 0; cyc = 0;
    while (idx < exp.size() && cyc < 200) begin
      checks++; if (valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL scan_flags d=%h got v=%0b b=%0b dn=%0b want 1 1 0", snap, valid, busy, done); end
      checks++; if (a !== 3'(exp[idx])) begin errors++; $display("FAIL scan_index d=%h n=%0d got a=%0d want %0d", snap, idx, a, exp[idx]); end
      checks++; if (total !== 4'(cnt)) begin errors++; $display("FAIL scan_total d=%h got %0d want %0d", snap, total, cnt); end
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom);
      ready = r;
      if ($urandom_range(0, 3) == 0) start = 1'b1;
      step();
      start = 1'b0;
      if (r) idx++;
      cyc++;
    end
    checks++; if (idx != exp.size()) begin errors++; $display("FAIL scan_timeout d=%h got %0d handshakes want %0d", snap, idx, exp.size()); end
    ready = 1'b0;
    checks++; if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL done_cycle d=%h got dn=%0b v=%0b b=%0b want 1 0 1", snap, done, valid, busy); end
    step();
    checks++; if (done !== 1'b0 || valid !== 1'b0 || busy !== 1'b0 || a !== 3'd0) begin errors++; $display("FAIL back_idle d=%h got dn=%0b v=%0b b=%0b a=%0d want 0 0 0 0", snap, done, valid, busy, a); end
    checks++; if (total !== 4'(cnt)) begin errors++; $display("FAIL total_hold d=%h got %0d want %0d", snap, total, cnt); end
  endtask

  task automatic test_ignore_start();
    int exp[$];
    int cnt;
    model(8'h81, exp, cnt);
    d = 8'h81; start = 1'b1; ready = 1'b0;
    step();
    start = 1'b1; d = 8'h7E;
    checks++; if (valid !== 1'b1 || a !== 3'(exp[0])) begin errors++; $display("FAIL ign_first got v=%0b a=%0d want 1 %0d", valid, a, exp[0]); end
    step();
    checks++; if (valid !== 1'b1 || a !== 3'(exp[0])) begin errors++; $display("FAIL ign_hold got v=%0b a=%0d want 1 %0d", valid, a, exp[0]); end
    ready = 1'b1;
    step();
    checks++; if (valid !== 1'b1 || a !== 3'(exp[1])) begin errors++; $display("FAIL ign_second got v=%0b a=%0d want 1 %0d", valid, a, exp[1]); end
    step();
    checks++; if (done !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL ign_done got dn=%0b v=%0b want 1 0", done, valid); end
    step();
    start = 1'b0; ready = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || total !== 4'd2) begin errors++; $display("FAIL ign_idle got b=%0b dn=%0b t=%0d want 0 0 2", busy, done, total); end
    step();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ign_single_done got b=%0b dn=%0b want 0 0", busy, done); end
  endtask

  task automatic test_reset_mid_scan();
    int exp[$];
    int cnt;
    model(8'h0F, exp, cnt);
    d = 8'h0F; start = 1'b1; ready = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++; if (valid !== 1'b1 || a !== 3'(exp[1])) begin errors++; $display("FAIL rst_pre got v=%0b a=%0d want 1 %0d", valid, a, exp[1]); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({a, valid, busy, done, total} !== 10'd0) begin errors++; $display("FAIL rst_async got a=%0d v=%0b b=%0b dn=%0b t=%0d want all 0", a, valid, busy, done, total); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL rst_no_done got dn=%0b b=%0b v=%0b want 0 0 0", done, busy, valid); end
    end
    ready = 1'b0;
    test_capture(8'h10, 0);
  endtask

  initial begin
    d = 8'h00; start = 1'b0; ready = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_capture(8'b1010_0100, 0);
    test_capture(8'h00, 0);
    test_capture(8'hFF, 1);
    test_ignore_start();
    test_reset_mid_scan();
    test_capture(8'h80, 1);
    test_capture(8'h01, 2);
    for (int n = 0; n < 30; n++) test_capture(8'($urandom), 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/codificador_sequencial.md
CODIFICADOR_SEQUENCIAL -- requirements
Module: codificador_sequencial

Interface
REQ-001 The block SHALL have no parameters; input width is fixed at 8 lines and index width at 3 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset; asserting it acts immediately, and deassertion is synchronised externally.
REQ-004 d  input  8  one-hot-or-more request lines; sampled only when a capture is accepted.
REQ-005 start  input  1  capture request; honoured only in IDLE.
REQ-006 ready  input  1  consumer accepts the current index when high with valid high.
REQ-007 a  output  3  encoded index of the current set bit in the captured snapshot.
REQ-008 valid  output  1  a holds a valid index awaiting acceptance.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 done  output  1  one-cycle pulse marking the end of a scan.
REQ-011 total  output  4  population count (0..8) of the last captured snapshot.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-013 In IDLE with start=1 at a rising edge, the block SHALL load d into an internal 8-bit mask, load total with popcount(d), and go to SCAN if d!=0, otherwise to DONE.
REQ-014 In SCAN, valid SHALL be 1 and a SHALL equal the index of the lowest set bit of the mask, so valid is first high in the cycle after start is sampled.
REQ-015 In SCAN, on a rising edge with ready=1, the block SHALL clear the mask bit indexed by a; if the mask becomes zero it SHALL go to DONE, otherwise it SHALL stay in SCAN with a updated to the next index.
REQ-016 In SCAN with ready=0, mask, a and valid SHALL hold stable.
REQ-017 DONE SHALL last exactly one cycle with done=1 and valid=0, then return to IDLE unconditionally.
REQ-018 start SHALL be ignored in SCAN and DONE; d changes after capture SHALL have no effect until the next capture.
REQ-019 A snapshot with k set bits SHALL produce exactly k handshakes, with indices in strictly increasing order.
REQ-020 All outputs SHALL be derived only from internal registers, with no combinational path from d, start or ready.
REQ-021 In IDLE, a SHALL be 0 and valid SHALL be 0; total SHALL retain its last value.
REQ-022 An all-zero capture SHALL pass IDLE->DONE->IDLE, with one done pulse, no valid, and total=0.
REQ-023 With ready held at 1, a k-bit snapshot SHALL complete in k cycles of SCAN plus one cycle of DONE.

Reset
REQ-024 While rst_n=0, the block SHALL be in IDLE with mask=0, a=0, valid=0, busy=0, done=0 and total=0.
REQ-025 Reset asserted mid-SCAN or in DONE SHALL immediately discard the snapshot with no done pulse; after release, the block SHALL wait in IDLE for a new start.

Configuration
REQ-026 With macro CODIFICADOR_MSB_FIRST_EN defined, a SHALL select the highest set bit of the mask and the indices SHALL be emitted in strictly decreasing order.
REQ-027 Without CODIFICADOR_MSB_FIRST_EN, the block SHALL use the lowest-first order of REQ-014 and REQ-019; all other behaviour SHALL be identical in both builds.

Verification
REQ-028 Reset, then start with d=8'b1010_0100 and ready=1 -> valid high for 3 cycles with a=2, 5, 7, then a one-cycle done pulse, total=3, busy low afterwards.
REQ-029 Start with d=8'h00 -> busy high for 1 cycle, done pulse, valid never high, total=0.
REQ-030 Start with d=8'hFF and ready toggling 1,0,1,0 -> a advances only on ready=1 cycles, giving a=0..7 in order, each held stable while ready=0, then done; total=8.
REQ-031 Capture d=8'h81, then change d to 8'h7E and pulse start during SCAN -> output is still a=0, 7 only, with a single done pulse.
REQ-032 Drop rst_n for 1 cycle during SCAN after the first handshake of d=8'h0F -> all outputs are immediately 0, there is no done pulse, and a new start with d=8'h10 yields a=4.
REQ-033 Build with CODIFICADOR_MSB_FIRST_EN and d=8'b1010_0100 -> a=7, 5, 2, then done.
